dcm_supervisor: RTL and testbench
=================================

DCM_SUPERVISOR -- requirements
Module: dcm_supervisor

Interface
REQ-001 Parameter RST_CYCLES, default 4: width of each dcm_rst pulse in clk cycles, minimum 3.
REQ-002 Parameter LOCK_TIMEOUT, default 1023: clk cycles allowed in WAIT_LOCK before a retry.
REQ-003 Parameter SETTLE_CYCLES, default 127: consecutive locked cycles required before sys_rst releases.
REQ-004 Parameter MAX_RETRIES, default 4: failed lock attempts tolerated before FAULT.
REQ-005 clk  input  1  single free-running clock, DCM input clock domain; all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 lock  input  1  DCM LOCKED, asynchronous to clk.
REQ-008 dcm_rst  output  1  reset request to DCM RST pin, active-high.
REQ-009 sys_rst  output  1  downstream system reset, active-high, asserted until clocks are stable.
REQ-010 fault  output  1  sticky; set when the retry budget is exhausted.
REQ-011 retries  output  3  count of lock attempts that failed since the last rst.

Function
REQ-012 lock SHALL pass through a two-flop synchronizer; lock_s (2-cycle latency) is the only lock source for control logic.
REQ-013 FSM states SHALL be PULSE, WAIT_LOCK, SETTLE, RUN and FAULT; one shared down/up counter, wide enough for max(LOCK_TIMEOUT, SETTLE_CYCLES).
REQ-014 PULSE: dcm_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with counter cleared.
REQ-015 WAIT_LOCK: lock_s=1 -> SETTLE, counter cleared; counter reaching LOCK_TIMEOUT with lock_s=0 -> failed attempt.
REQ-016 SETTLE: lock_s=0 on any cycle -> failed attempt; SETTLE_CYCLES consecutive lock_s=1 cycles -> RUN.
REQ-017 RUN: sys_rst=0; lock_s=0 -> PULSE; this lock loss SHALL NOT increment retries.
REQ-018 Failed attempt: retries increments, saturating at 7; if the new value equals MAX_RETRIES -> FAULT, else -> PULSE.
REQ-019 FAULT: dcm_rst=0, sys_rst=1, fault=1; stay in FAULT until rst, ignoring lock.
REQ-020 All outputs SHALL be registered; sys_rst=1 in every state except RUN, and SHALL assert on the cycle after the RUN->PULSE transition edge.
REQ-021 If timeout and lock_s rise coincide in WAIT_LOCK, lock wins (-> SETTLE).
REQ-022 dcm_rst SHALL never be asserted while sys_rst=0.

Reset
REQ-023 On rst=1: state=PULSE, counter=0, dcm_rst=1, sys_rst=1, fault=0, retries=0, synchronizer flops=0.
REQ-024 rst asserted mid-operation (any state including FAULT) SHALL restart the full sequence from PULSE on the following cycle.

Structure
REQ-025 Shared package dcm_supervisor_pkg SHALL hold the state typedef and the default parameter constants.
REQ-026 The synchronizer SHALL be a separate sub-module sync2 (1-bit, reset to 0), reusable elsewhere.
REQ-027 Target size 120-400 lines RTL; no clock gating or derived clocks inside the block.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=3)
REQ-028 Release rst, raise lock at cycle 10 -> dcm_rst high cycles 1-4, sys_rst falls exactly 8 cycles after lock_s rises, retries=0.
REQ-029 Lock never rises -> three timeout pulses of 4 cycles each, retries 1,2,3, then fault=1, dcm_rst=0, sys_rst=1 held for 200 cycles.
REQ-030 Lock rises then drops 3 cycles into SETTLE -> retries=1, new 4-cycle dcm_rst pulse, sys_rst never deasserts.
REQ-031 In RUN, drop lock for 1 cycle -> sys_rst=1 within 3 cycles of the drop, new dcm_rst pulse, retries unchanged, RUN reached again after relock.
REQ-032 Assert rst for 1 cycle while in FAULT -> fault=0, retries=0, dcm_rst=1 next cycle, normal lock sequence completes.
REQ-033 Lock_s rise on the same cycle as timeout -> SETTLE entered, retries unchanged.

Source files
------------

// File: rtl/dcm_supervisor_pkg.sv
// Shared types and default tuning constants for the DCM lock supervisor.
package dcm_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_PULSE,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam int DEF_RST_CYCLES    = 4;
    localparam int DEF_LOCK_TIMEOUT  = 1023;
    localparam int DEF_SETTLE_CYCLES = 127;
    localparam int DEF_MAX_RETRIES   = 4;

    localparam int RETRY_W = 3;

    // Counter width large enough to hold the largest of the three phase lengths.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcm_supervisor.sv
// Sequences DCM reset pulses, waits for a stable lock, and holds the system
// in reset until the clock has settled; gives up after a bounded retry budget.
module dcm_supervisor
    import dcm_supervisor_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lock,
    output logic               dcm_rst,
    output logic               sys_rst,
    output logic               fault,
    output logic [RETRY_W-1:0] retries
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

    localparam logic [CW-1:0]      PULSE_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]      TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]      SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_SAT    = '1;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                lock_s;
    logic                attempt_failed;
    logic                give_up;
    logic [RETRY_W-1:0]  retries_nxt;

    sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (lock),
        .q   (lock_s)
    );

    // A lock seen on the final timeout cycle still counts as a lock.
    always_comb begin
        attempt_failed = 1'b0;
        if (state == ST_WAIT_LOCK && !lock_s && cnt == TIMEOUT_LAST)
            attempt_failed = 1'b1;
        if (state == ST_SETTLE && !lock_s)
            attempt_failed = 1'b1;
    end

    assign retries_nxt = (retries == RETRY_SAT) ? retries : retries + RETRY_W'(1);
    assign give_up     = (retries_nxt == RETRY_LIMIT);

    // Each phase occupies exactly its configured number of cycles; cnt counts
    // cycles already spent in the current phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_PULSE;
            cnt     <= '0;
            dcm_rst <= 1'b1;
            sys_rst <= 1'b1;
            fault   <= 1'b0;
            retries <= '0;
        end else if (attempt_failed) begin
            retries <= retries_nxt;
            cnt     <= '0;
            sys_rst <= 1'b1;
            if (give_up) begin
                state   <= ST_FAULT;
                dcm_rst <= 1'b0;
                fault   <= 1'b1;
            end else begin
                state   <= ST_PULSE;
                dcm_rst <= 1'b1;
            end
        end else begin
            case (state)
                ST_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        state   <= ST_WAIT_LOCK;
                        cnt     <= '0;
                        dcm_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= ST_SETTLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state   <= ST_RUN;
                        cnt     <= '0;
                        sys_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    // Lock loss while running restarts without spending a retry.
                    if (!lock_s) begin
                        state   <= ST_PULSE;
                        cnt     <= '0;
                        dcm_rst <= 1'b1;
                        sys_rst <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    dcm_rst <= 1'b0;
                    sys_rst <= 1'b1;
                    fault   <= 1'b1;
                end
                default: begin
                    state   <= ST_PULSE;
                    cnt     <= '0;
                    dcm_rst <= 1'b1;
                    sys_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcm_supervisor.sv
// Randomized scoreboard bench for dcm_supervisor against a phase/age reference model.
module tb_dcm_supervisor;

    localparam int RC = 4;
    localparam int LT = 20;
    localparam int SC = 8;
    localparam int MR = 3;

    localparam int M_PULSE  = 0;
    localparam int M_WAIT   = 1;
    localparam int M_SETTLE = 2;
    localparam int M_RUN    = 3;
    localparam int M_FAULT  = 4;

    typedef struct packed {
        logic       dcm;
        logic       sys;
        logic       flt;
        logic [2:0] ret;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       dcm_rst;
    logic       sys_rst;
    logic       fault;
    logic [2:0] retries;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // reference model: phase, cycles spent in phase, failed attempts, lock history
    int   ph = M_PULSE;
    int   age = 0;
    int   ret = 0;
    logic h0 = 1'b0;
    logic h1 = 1'b0;

    always #5 clk = ~clk;

    dcm_supervisor #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (SC),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lock    (lock),
        .dcm_rst (dcm_rst),
        .sys_rst (sys_rst),
        .fault   (fault),
        .retries (retries)
    );

    function automatic obs_t model_out();
        obs_t o;
        o.dcm = (ph == M_PULSE);
        o.sys = (ph != M_RUN);
        o.flt = (ph == M_FAULT);
        o.ret = 3'(ret);
        return o;
    endfunction

    task automatic attempt_failed();
        ret = (ret < 7) ? ret + 1 : 7;
        ph  = (ret == MR) ? M_FAULT : M_PULSE;
        age = 0;
    endtask

    // Advance the model by one clock edge; lock reaches control logic two edges late.
    task automatic model_edge(input logic r, input logic l);
        logic ls;
        if (r) begin
            ph = M_PULSE; age = 0; ret = 0; h0 = 1'b0; h1 = 1'b0;
            return;
        end
        ls = h1;
        h1 = h0;
        h0 = l;
        case (ph)
            M_PULSE: begin
                age++;
                if (age == RC) begin ph = M_WAIT; age = 0; end
            end
            M_WAIT: begin
                age++;
                if (ls) begin ph = M_SETTLE; age = 0; end
                else if (age == LT) attempt_failed();
            end
            M_SETTLE: begin
                if (!ls) attempt_failed();
                else begin
                    age++;
                    if (age == SC) begin ph = M_RUN; age = 0; end
                end
            end
            M_RUN: begin
                if (!ls) begin ph = M_PULSE; age = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic step(input logic r, input logic l);
        rst  = r;
        lock = l;
        model_edge(r, l);
        @(posedge clk);
        exp_q.push_back(model_out());
        cyc++;
        #1;
    endtask

    task automatic hold(input int n, input logic l);
        repeat (n) step(1'b0, l);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a.dcm = dcm_rst;
            mon_a.sys = sys_rst;
            mon_a.flt = fault;
            mon_a.ret = retries;
            total++;
            if (mon_a !== mon_e) begin
                bad++;
                $display("FAIL outputs t=%0t got dcm=%b sys=%b fault=%b retries=%0d want dcm=%b sys=%b fault=%b retries=%0d",
                         $time, mon_a.dcm, mon_a.sys, mon_a.flt, mon_a.ret,
                         mon_e.dcm, mon_e.sys, mon_e.flt, mon_e.ret);
            end
            total++;
            if (dcm_rst === 1'b1 && sys_rst !== 1'b1) begin
                bad++;
                $display("FAIL dcm_rst_while_running t=%0t got dcm=%b sys=%b want sys=1",
                         $time, dcm_rst, sys_rst);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got timeout want completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // normal bring-up: lock rises at cycle 10
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        hold(10, 1'b0);
        hold(60, 1'b1);

        // one-cycle lock loss while running, then relock
        hold(1, 1'b0);
        hold(60, 1'b1);

        // lock drops a few cycles into settle
        step(1'b1, 1'b0);
        for (int i = 0; i < 100 && ph != M_SETTLE; i++) step(1'b0, 1'b1);
        hold(1, 1'b1);
        hold(30, 1'b0);
        hold(60, 1'b1);

        // lock never rises: three timeouts then fault, lock ignored afterwards
        step(1'b1, 1'b0);
        hold(120, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b0, 1'($urandom % 2));

        // one-cycle rst out of fault, then a normal lock sequence
        step(1'b1, 1'b0);
        hold(10, 1'b0);
        hold(60, 1'b1);

        // lock_s rise coinciding with the timeout cycle
        step(1'b1, 1'b0);
        for (int i = 0; i < 100 && !(ph == M_WAIT && age == LT - 3); i++) step(1'b0, 1'b0);
        hold(40, 1'b1);

        // random lock runs with occasional resets
        for (int k = 0; k < 40; k++) begin
            int   n;
            logic l;
            n = $urandom_range(1, 40);
            l = 1'($urandom % 2);
            if ($urandom % 10 == 0) step(1'b1, l);
            hold(n, l);
        end

        hold(3, 1'b0);
        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
